// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    ADD   = 2'b00,
    SUB   = 2'b01,
    FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       mem2reg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    aluop_t     aluop;
  } ctrl_t;

  // Control word for a state; last marks the final dwell cycle of FETCH.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic last);
    ctrl_t c;
    c = '0;
    c.aluop = ADD;
    case (s)
      S_FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = last;
        c.pcwrite = last;
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB: begin
        c.mem2reg  = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU sub-decoder: ALUOp plus Funct field to a 3-bit ALUControl code.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);

  always_comb begin
    o_alucontrol = ALUC_ADD;
    case (i_aluop)
      ADD: o_alucontrol = ALUC_ADD;
      SUB: o_alucontrol = ALUC_SUB;
      FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alucontrol = ALUC_ADD;
          FN_SUB:  o_alucontrol = ALUC_SUB;
          FN_AND:  o_alucontrol = ALUC_AND;
          FN_OR:   o_alucontrol = ALUC_OR;
          FN_SLT:  o_alucontrol = ALUC_SLT;
          default: o_alucontrol = ALUC_ADD;
        endcase
      end
      default: o_alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM (lw, sw, R-type, beq, addi, j) with MEM_LAT memory dwell.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes and expose the Illegal output.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       Mem2Reg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic       Illegal,
`endif
  output logic [2:0] ALUControl
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  ctrl_t      r_ctrl;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       r_illegal;
`endif

  state_t     w_nstate;
  logic [3:0] w_ncnt;
  logic       w_last;
  logic       w_nlast;
  logic [2:0] w_alucontrol;

  always_comb begin
    w_last   = (r_cnt == LAT_M1);
    w_nstate = r_state;
    case (r_state)
      S_FETCH:  if (w_last) w_nstate = S_DECODE;
      S_DECODE: begin
        case (OP)
          OP_LW, OP_SW: w_nstate = S_MEMADR;
          OP_RTYPE:     w_nstate = S_EXECUTE;
          OP_BEQ:       w_nstate = S_BRANCH;
          OP_ADDI:      w_nstate = S_ADDIEX;
          OP_J:         w_nstate = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:      w_nstate = S_TRAP;
`else
          default:      w_nstate = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  w_nstate = (OP == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (w_last) w_nstate = S_MEMWB;
      S_MEMWB:   w_nstate = S_FETCH;
      S_MEMWR:   if (w_last) w_nstate = S_FETCH;
      S_EXECUTE: w_nstate = S_ALUWB;
      S_ALUWB:   w_nstate = S_FETCH;
      S_BRANCH:  w_nstate = S_FETCH;
      S_ADDIEX:  w_nstate = S_ADDIWB;
      S_ADDIWB:  w_nstate = S_FETCH;
      S_JUMP:    w_nstate = S_FETCH;
      S_TRAP:    w_nstate = S_TRAP;
      default:   w_nstate = S_FETCH;
    endcase
    w_ncnt  = (w_nstate != r_state) ? '0 : r_cnt + 4'd1;
    w_nlast = (w_ncnt == LAT_M1);
  end

  // Outputs are registered from the next state, so the reset value must already
  // be the FETCH/cnt=0 control word (IRWrite/PCWrite set when MEM_LAT is 1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_ctrl    <= decode_ctrl(S_FETCH, LAT_M1 == 4'd0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      r_state   <= w_nstate;
      r_cnt     <= w_ncnt;
      r_ctrl    <= decode_ctrl(w_nstate, w_nlast);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      r_illegal <= (w_nstate == S_TRAP);
`endif
    end
  end

  mc_alu_decoder u_alu_dec (
    .i_aluop      (r_ctrl.aluop),
    .i_funct      (Funct),
    .o_alucontrol (w_alucontrol)
  );

  // Write strobes are gated so they are low for the whole reset assertion.
  assign PCEn       = ~reset & (r_ctrl.pcwrite | (r_ctrl.branch & Zero));
  assign IRWrite    = ~reset & r_ctrl.irwrite;
  assign RegWrite   = ~reset & r_ctrl.regwrite;
  assign MemWrite   = ~reset & r_ctrl.memwrite;
  assign IorD       = r_ctrl.iord;
  assign RegDst     = r_ctrl.regdst;
  assign Mem2Reg    = r_ctrl.mem2reg;
  assign ALUSrcA    = r_ctrl.alusrca;
  assign ALUSrcB    = r_ctrl.alusrcb;
  assign PCSrc      = r_ctrl.pcsrc;
  assign ALUControl = w_alucontrol;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign Illegal    = r_illegal;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: MEM_LAT=1 instance for lw/R/beq/addi/j/illegal, MEM_LAT=3 instance for sw and reset.
module tb_multicycle_controller;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, rst3, zero;
  logic [5:0] op, funct;

  logic       pcen1, iord1, memw1, irw1, regw1, regdst1, m2r1, srca1;
  logic [1:0] srcb1, pcsrc1;
  logic [2:0] aluc1;
  logic       pcen3, iord3, memw3, irw3, regw3, regdst3, m2r3, srca3;
  logic [1:0] srcb3, pcsrc3;
  logic [2:0] aluc3;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       ill1, ill3;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  multicycle_controller #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst1), .OP(op), .Funct(funct), .Zero(zero),
    .PCEn(pcen1), .IorD(iord1), .MemWrite(memw1), .IRWrite(irw1), .RegWrite(regw1),
    .RegDst(regdst1), .Mem2Reg(m2r1), .ALUSrcA(srca1), .ALUSrcB(srcb1), .PCSrc(pcsrc1),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    .Illegal(ill1),
`endif
    .ALUControl(aluc1)
  );

  multicycle_controller #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(rst3), .OP(op), .Funct(funct), .Zero(zero),
    .PCEn(pcen3), .IorD(iord3), .MemWrite(memw3), .IRWrite(irw3), .RegWrite(regw3),
    .RegDst(regdst3), .Mem2Reg(m2r3), .ALUSrcA(srca3), .ALUSrcB(srcb3), .PCSrc(pcsrc3),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    .Illegal(ill3),
`endif
    .ALUControl(aluc3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; op = OP_RTYPE; funct = 6'd0; zero = 1'b1;
    tick(); tick();
    chk("rst_state1", 32'(u_dut1.r_state), 32'(S_FETCH));
    chk("rst_pcen1",  32'(pcen1), 32'd0);
    chk("rst_irw1",   32'(irw1),  32'd0);
    chk("rst_regw1",  32'(regw1), 32'd0);
    chk("rst_memw3",  32'(memw3), 32'd0);
    chk("rst_cnt3",   32'(u_dut3.r_cnt), 32'd0);

    // ---- lw, MEM_LAT=1 ----
    zero = 1'b0; op = OP_LW;
    rst1 = 1'b0; #1;
    chk("lw_f_irw",   32'(irw1),  32'd1);
    chk("lw_f_pcen",  32'(pcen1), 32'd1);
    chk("lw_f_srcb",  32'(srcb1), 32'b01);
    chk("lw_f_iord",  32'(iord1), 32'd0);
    tick();
    chk("lw_d_state", 32'(u_dut1.r_state), 32'(S_DECODE));
    chk("lw_d_srcb",  32'(srcb1), 32'b11);
    chk("lw_d_irw",   32'(irw1),  32'd0);
    chk("lw_d_regw",  32'(regw1), 32'd0);
    tick();
    chk("lw_a_state", 32'(u_dut1.r_state), 32'(S_MEMADR));
    chk("lw_a_srca",  32'(srca1), 32'd1);
    chk("lw_a_srcb",  32'(srcb1), 32'b10);
    chk("lw_a_regw",  32'(regw1), 32'd0);
    tick();
    chk("lw_r_state", 32'(u_dut1.r_state), 32'(S_MEMRD));
    chk("lw_r_iord",  32'(iord1), 32'd1);
    chk("lw_r_regw",  32'(regw1), 32'd0);
    tick();
    chk("lw_wb_state", 32'(u_dut1.r_state), 32'(S_MEMWB));
    chk("lw_wb_regw",  32'(regw1), 32'd1);
    chk("lw_wb_m2r",   32'(m2r1),  32'd1);
    chk("lw_wb_rdst",  32'(regdst1), 32'd0);
    tick();
    chk("lw_end_state", 32'(u_dut1.r_state), 32'(S_FETCH));
    chk("lw_end_regw",  32'(regw1), 32'd0);

    // ---- R-type slt ----
    op = OP_RTYPE; funct = FN_SLT;
    tick(); tick();
    chk("r_ex_state", 32'(u_dut1.r_state), 32'(S_EXECUTE));
    chk("r_ex_aluc",  32'(aluc1), 32'b111);
    chk("r_ex_srca",  32'(srca1), 32'd1);
    chk("r_ex_srcb",  32'(srcb1), 32'b00);
    funct = 6'b111000;
    #1 chk("r_ex_aluc_unk", 32'(aluc1), 32'b010);
    funct = FN_OR;
    #1 chk("r_ex_aluc_or", 32'(aluc1), 32'b001);
    tick();
    chk("r_wb_state", 32'(u_dut1.r_state), 32'(S_ALUWB));
    chk("r_wb_rdst",  32'(regdst1), 32'd1);
    chk("r_wb_regw",  32'(regw1), 32'd1);
    chk("r_wb_m2r",   32'(m2r1), 32'd0);
    tick();
    chk("r_end_state", 32'(u_dut1.r_state), 32'(S_FETCH));

    // ---- beq taken / not taken ----
    op = OP_BEQ;
    tick(); tick();
    chk("beqt_state", 32'(u_dut1.r_state), 32'(S_BRANCH));
    chk("beqt_pcen0", 32'(pcen1), 32'd0);
    zero = 1'b1; #1;
    chk("beqt_pcen1", 32'(pcen1), 32'd1);
    chk("beqt_pcsrc", 32'(pcsrc1), 32'b01);
    chk("beqt_aluc",  32'(aluc1), 32'b110);
    tick();
    chk("beqt_end", 32'(u_dut1.r_state), 32'(S_FETCH));
    zero = 1'b0;
    tick(); tick();
    chk("beqn_pcen",  32'(pcen1), 32'd0);
    chk("beqn_pcsrc", 32'(pcsrc1), 32'b01);
    tick();
    chk("beqn_end", 32'(u_dut1.r_state), 32'(S_FETCH));

    // ---- addi then j ----
    op = OP_ADDI;
    tick(); tick();
    chk("addi_ex_state", 32'(u_dut1.r_state), 32'(S_ADDIEX));
    chk("addi_ex_srcb",  32'(srcb1), 32'b10);
    chk("addi_ex_aluc",  32'(aluc1), 32'b010);
    tick();
    chk("addi_wb_rdst", 32'(regdst1), 32'd0);
    chk("addi_wb_regw", 32'(regw1), 32'd1);
    tick();
    op = OP_J;
    tick(); tick();
    chk("j_state", 32'(u_dut1.r_state), 32'(S_JUMP));
    chk("j_pcsrc", 32'(pcsrc1), 32'b10);
    chk("j_pcen",  32'(pcen1), 32'd1);
    tick();
    chk("j_end", 32'(u_dut1.r_state), 32'(S_FETCH));

    // ---- unknown opcode ----
    op = 6'b111111; zero = 1'b1;
    tick(); tick();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    chk("ill_state", 32'(u_dut1.r_state), 32'(S_TRAP));
    chk("ill_flag",  32'(ill1), 32'd1);
    chk("ill_pcen",  32'(pcen1), 32'd0);
    chk("ill_irw",   32'(irw1), 32'd0);
    tick();
    chk("ill_stay",  32'(u_dut1.r_state), 32'(S_TRAP));
    rst1 = 1'b1; #1;
    chk("ill_clr",   32'(ill1), 32'd0);
`else
    chk("ill_state", 32'(u_dut1.r_state), 32'(S_FETCH));
    chk("ill_irw",   32'(irw1), 32'd1);
    rst1 = 1'b1; #1;
`endif

    // ---- sw, MEM_LAT=3 ----
    zero = 1'b0; op = OP_SW;
    rst3 = 1'b0; #1;
    chk("sw_f0_irw", 32'(irw3), 32'd0);
    chk("sw_f0_pcen", 32'(pcen3), 32'd0);
    tick();
    chk("sw_f1_irw", 32'(irw3), 32'd0);
    chk("sw_f1_state", 32'(u_dut3.r_state), 32'(S_FETCH));
    tick();
    chk("sw_f2_irw",  32'(irw3), 32'd1);
    chk("sw_f2_pcen", 32'(pcen3), 32'd1);
    tick();
    chk("sw_d_state", 32'(u_dut3.r_state), 32'(S_DECODE));
    tick();
    chk("sw_a_memw", 32'(memw3), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sw_wr%0d_memw", i), 32'(memw3), 32'd1);
      chk($sformatf("sw_wr%0d_iord", i), 32'(iord3), 32'd1);
      chk($sformatf("sw_wr%0d_cnt", i),  32'(u_dut3.r_cnt), 32'(i));
    end
    tick();
    chk("sw_end_state", 32'(u_dut3.r_state), 32'(S_FETCH));
    chk("sw_end_memw",  32'(memw3), 32'd0);
    chk("sw_end_cnt",   32'(u_dut3.r_cnt), 32'd0);

    // ---- reset during 2nd MEMWR cycle ----
    for (int i = 0; i < 6; i++) tick();
    chk("rmid_state", 32'(u_dut3.r_state), 32'(S_MEMWR));
    chk("rmid_memw",  32'(memw3), 32'd1);
    chk("rmid_cnt",   32'(u_dut3.r_cnt), 32'd1);
    rst3 = 1'b1; #1;
    chk("rmid_now_memw",  32'(memw3), 32'd0);
    chk("rmid_now_state", 32'(u_dut3.r_state), 32'(S_FETCH));
    chk("rmid_now_cnt",   32'(u_dut3.r_cnt), 32'd0);
    tick();
    rst3 = 1'b0; #1;
    chk("rrel_memw",  32'(memw3), 32'd0);
    chk("rrel_irw",   32'(irw3), 32'd0);
    tick();
    chk("rrel_cnt1",  32'(u_dut3.r_cnt), 32'd1);
    chk("rrel_memw1", 32'(memw3), 32'd0);
    tick();
    chk("rrel_irw2",  32'(irw3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
